le18_port_ctrl: RTL and testbench



---
 rtl/le18_port_ctrl.sv | 140 ++++++++++++++
 tb/tb_le18_port_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/le18_port_ctrl.sv
// Z80 I/O front-end for the LE18 graphics plane: decodes ports 0xEC-0xEF,
// holds the X/Y/option registers and sequences RAM port A strobes.
module le18_port_ctrl #(
  parameter int unsigned Y_LAST = 191
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  TRS_A,
  input  logic [7:0]  TRS_D,
  input  logic        TRS_IN,
  input  logic        TRS_OUT,
  input  logic        io_access,
  input  logic        splash_en,
  input  logic        vid_blank,
  output logic        ram_ce,
  output logic        ram_we,
  output logic        ram_oce,
  output logic [13:0] ram_addr,
  output logic [5:0]  ram_din,
  input  logic [5:0]  ram_dout,
  output logic [7:0]  dout,
  output logic        dout_rdy,
  output logic        le18_enable
);

  localparam logic [7:0] YLast = 8'(Y_LAST);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_WAIT, S_WR, S_RD_CE, S_RD_OCE, S_RD_RDY, S_ST_RDY
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [2:0]  opt_q, opt_d;     // {incy, incx, en}
  logic [5:0]  din_q, din_d;
  logic [7:0]  dout_q, dout_d;
  logic        post_inc;
  logic        wr_acc, rd_acc;

  assign wr_acc      = io_access & ~TRS_OUT;
  assign rd_acc      = io_access & ~TRS_IN;
  assign le18_enable = opt_q[0] | splash_en;
  assign ram_addr    = {y_q, x_q};
  assign ram_din     = din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      opt_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      opt_q   <= opt_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    opt_d    = opt_q;
    din_d    = din_q;
    dout_d   = dout_q;
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_oce  = 1'b0;
    dout_rdy = 1'b0;
    dout     = dout_q;
    post_inc = 1'b0;

    unique case (state_q)
      // Accesses are only decoded while idle; anything else is dropped.
      S_IDLE: begin
        if (wr_acc) begin
          unique case (TRS_A)
            8'hEC: begin
              state_d = S_WR_WAIT;
              din_d   = TRS_D[5:0];
            end
            8'hED: x_d = TRS_D[5:0];
            8'hEE: y_d = TRS_D;
            8'hEF: if (!splash_en) opt_d = TRS_D[2:0];
            default: ;
          endcase
        end else if (rd_acc) begin
          unique case (TRS_A)
            8'hEC:   state_d = S_RD_CE;
            8'hEF:   state_d = S_ST_RDY;
            default: ;
          endcase
        end
      end
      S_WR_WAIT: state_d = S_WR;
      S_WR: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        post_inc = 1'b1;
        state_d  = S_IDLE;
      end
      S_RD_CE: begin
        ram_ce  = 1'b1;
        state_d = S_RD_OCE;
      end
      S_RD_OCE: begin
        ram_oce = 1'b1;
        state_d = S_RD_RDY;
      end
      // Read data is passed straight through in the ready cycle and held after.
      S_RD_RDY: begin
        dout     = {vid_blank, le18_enable, ram_dout};
        dout_d   = dout;
        dout_rdy = 1'b1;
        post_inc = 1'b1;
        state_d  = S_IDLE;
      end
      S_ST_RDY: begin
        dout     = {vid_blank, le18_enable, 3'b000, opt_q};
        dout_d   = dout;
        dout_rdy = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (post_inc && opt_q[1]) begin
      x_d = x_q + 6'd1;
      if (x_q == 6'd63 && opt_q[2])
        y_d = (y_q == YLast) ? '0 : y_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_le18_port_ctrl.sv
// Directed plus randomized checks of le18_port_ctrl against an arithmetic
// reference of the X/Y/option registers and a shadow copy of the frame RAM.
module tb_le18_port_ctrl;

  localparam int YL = 191;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  TRS_A, TRS_D;
  logic        TRS_IN, TRS_OUT, io_access, splash_en, vid_blank;
  logic        ram_ce, ram_we, ram_oce;
  logic [13:0] ram_addr;
  logic [5:0]  ram_din, ram_dout;
  logic [7:0]  dout;
  logic        dout_rdy, le18_enable;

  always #5 clk = ~clk;

  le18_port_ctrl #(.Y_LAST(YL)) dut (
    .clk(clk), .rst_n(rst_n), .TRS_A(TRS_A), .TRS_D(TRS_D),
    .TRS_IN(TRS_IN), .TRS_OUT(TRS_OUT), .io_access(io_access),
    .splash_en(splash_en), .vid_blank(vid_blank),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_oce(ram_oce),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .dout(dout), .dout_rdy(dout_rdy), .le18_enable(le18_enable)
  );

  // Frame RAM port A with an output register enabled by ram_oce.
  logic [5:0] ram_mem [0:16383];
  always @(posedge clk) begin
    if (ram_ce && ram_we) ram_mem[ram_addr] <= ram_din;
    if (ram_oce) ram_dout <= ram_mem[ram_addr];
  end

  int         tests = 0, fails = 0;
  int         rx, ry;
  bit         r_en, r_incx, r_incy;
  bit   [5:0] ref_mem [16384];
  logic [7:0] ref_dout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_addr();
    return ry * 64 + rx;
  endfunction

  task automatic ref_inc();
    if (r_incx) begin
      rx = (rx + 1) % 64;
      if (rx == 0 && r_incy) ry = (ry == YL) ? 0 : (ry + 1) % 256;
    end
  endtask

  function automatic logic [7:0] status_exp();
    return {vid_blank, r_en | splash_en, 3'b000, r_incy, r_incx, r_en};
  endfunction

  // Called mid-cycle T; returns mid-cycle T+1.
  task automatic start(input bit is_out, input logic [7:0] port, input logic [7:0] data);
    TRS_A = port; TRS_D = data;
    TRS_OUT = !is_out; TRS_IN = is_out; io_access = 1'b1;
    @(negedge clk);
    io_access = 1'b0; TRS_OUT = 1'b1; TRS_IN = 1'b1;
  endtask

  task automatic reg_out(input logic [7:0] port, input logic [7:0] data);
    start(1'b1, port, data);
    case (port)
      8'hED: rx = data % 64;
      8'hEE: ry = data;
      8'hEF: if (!splash_en) {r_incy, r_incx, r_en} = data[2:0];
      default: ;
    endcase
    check("reg_addr", ram_addr, ref_addr());
    check("reg_le18_en", le18_enable, r_en | splash_en);
    check("reg_no_rdy", dout_rdy, 1'b0);
  endtask

  task automatic pix_write(input logic [7:0] data);
    int a;
    a = ref_addr();
    start(1'b1, 8'hEC, data);
    check("wr_t1_ce", ram_ce, 1'b0);
    check("wr_t1_we", ram_we, 1'b0);
    @(negedge clk);
    check("wr_t2_ce", ram_ce, 1'b1);
    check("wr_t2_we", ram_we, 1'b1);
    check("wr_t2_oce", ram_oce, 1'b0);
    check("wr_t2_addr", ram_addr, a);
    check("wr_t2_din", ram_din, data[5:0]);
    ref_mem[a] = data[5:0];
    @(negedge clk);
    check("wr_t3_we", ram_we, 1'b0);
    ref_inc();
    check("wr_t3_addr", ram_addr, ref_addr());
  endtask

  task automatic pix_read();
    int a;
    logic [7:0] exp;
    a = ref_addr();
    start(1'b0, 8'hEC, 8'h00);
    check("rd_t1_ce", ram_ce, 1'b1);
    check("rd_t1_we", ram_we, 1'b0);
    check("rd_t1_oce", ram_oce, 1'b0);
    @(negedge clk);
    check("rd_t2_ce", ram_ce, 1'b0);
    check("rd_t2_oce", ram_oce, 1'b1);
    check("rd_t2_rdy", dout_rdy, 1'b0);
    @(negedge clk);
    exp = {vid_blank, r_en | splash_en, ref_mem[a]};
    check("rd_t3_rdy", dout_rdy, 1'b1);
    check("rd_t3_dout", dout, exp);
    check("rd_t3_addr", ram_addr, a);
    ref_dout = exp;
    @(negedge clk);
    check("rd_t4_rdy", dout_rdy, 1'b0);
    check("rd_t4_hold", dout, ref_dout);
    ref_inc();
    check("rd_t4_addr", ram_addr, ref_addr());
  endtask

  task automatic stat_read();
    logic [7:0] exp;
    start(1'b0, 8'hEF, 8'h00);
    exp = status_exp();
    check("st_t1_rdy", dout_rdy, 1'b1);
    check("st_t1_dout", dout, exp);
    ref_dout = exp;
    @(negedge clk);
    check("st_t2_rdy", dout_rdy, 1'b0);
    check("st_t2_hold", dout, ref_dout);
  endtask

  initial begin
    logic [7:0] p;
    int a;
    rst_n = 1'b0; TRS_A = '0; TRS_D = '0; TRS_IN = 1'b1; TRS_OUT = 1'b1;
    io_access = 1'b0; splash_en = 1'b1; vid_blank = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i] <= 6'h00;
      ref_mem[i] = 6'h00;
    end
    ram_mem[645] <= 6'h15;
    ref_mem[645] = 6'h15;
    ram_dout <= 6'h00;
    rx = 0; ry = 0; r_en = 0; r_incx = 0; r_incy = 0; ref_dout = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_addr", ram_addr, 14'd0);
    check("rst_dout", dout, 8'h00);
    check("rst_rdy", dout_rdy, 1'b0);
    check("rst_strobes", {ram_ce, ram_we, ram_oce}, 3'b000);
    check("rst_din", ram_din, 6'h00);
    check("rst_le18_splash", le18_enable, 1'b1);
    splash_en = 1'b0;
    #1 check("rst_le18_nosplash", le18_enable, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Address setup, read of preloaded data, write, read-back.
    reg_out(8'hED, 8'd5);
    reg_out(8'hEE, 8'd10);
    check("addr_645", ram_addr, 14'd645);
    vid_blank = 1'b1;
    pix_read();
    check("read_0x95", ref_dout, 8'h95);
    pix_write(8'h2A);
    check("x_stays", ram_addr, 14'd645);
    pix_read();

    // Options port gated by splash.
    splash_en = 1'b1;
    reg_out(8'hEF, 8'h07);
    stat_read();
    splash_en = 1'b0;
    reg_out(8'hEF, 8'h07);
    stat_read();
    check("opts_111", dout[2:0], 3'b111);

    // Wrap cases.
    reg_out(8'hED, 8'd63); reg_out(8'hEE, 8'd191);
    pix_write(8'h11);
    pix_write(8'h22);
    check("wrap_xy_zero", ram_addr, 14'd1);
    reg_out(8'hEF, 8'h03);
    reg_out(8'hED, 8'd63); reg_out(8'hEE, 8'd191);
    pix_write(8'h33);
    check("wrap_x_only", ram_addr, 14'd12224);
    pix_write(8'h34);
    reg_out(8'hEF, 8'h07);
    reg_out(8'hED, 8'd63); reg_out(8'hEE, 8'd255);
    pix_write(8'h35);
    check("wrap_y255", ram_addr, 14'd0);
    reg_out(8'hEF, 8'h05);
    reg_out(8'hED, 8'd7); reg_out(8'hEE, 8'd9);
    pix_write(8'h36);
    pix_read();
    check("no_inc_incy_only", ram_addr, 14'd583);

    // Access during RD_OCE is dropped.
    reg_out(8'hEF, 8'h00);
    reg_out(8'hED, 8'd3); reg_out(8'hEE, 8'd4);
    a = ref_addr();
    start(1'b0, 8'hEC, 8'h00);
    check("ign_t1_ce", ram_ce, 1'b1);
    @(negedge clk);
    check("ign_t2_oce", ram_oce, 1'b1);
    TRS_A = 8'hED; TRS_D = 8'd9; TRS_OUT = 1'b0; io_access = 1'b1;
    @(negedge clk);
    io_access = 1'b0; TRS_OUT = 1'b1;
    check("ign_t3_rdy", dout_rdy, 1'b1);
    check("ign_t3_dout", dout, {vid_blank, 1'b0, ref_mem[a]});
    ref_dout = dout;
    @(negedge clk);
    check("ign_x_kept", ram_addr, a);
    check("ign_idle", {ram_ce, ram_oce, dout_rdy}, 3'b000);

    // Reset in WR_WAIT aborts the write.
    reg_out(8'hEF, 8'h07);
    reg_out(8'hED, 8'd20); reg_out(8'hEE, 8'd30);
    a = ref_addr();
    start(1'b1, 8'hEC, 8'h3F);
    rst_n = 1'b0;
    #1;
    check("arst_addr", ram_addr, 14'd0);
    check("arst_strobes", {ram_ce, ram_we, ram_oce}, 3'b000);
    check("arst_dout", dout, 8'h00);
    @(negedge clk);
    check("arst_no_we", ram_we, 1'b0);
    rst_n = 1'b1;
    rx = 0; ry = 0; r_en = 0; r_incx = 0; r_incy = 0; ref_dout = 8'h00;
    @(negedge clk);
    pix_write(8'h0C);
    stat_read();
    check("arst_mem_kept", ram_mem[a], ref_mem[a]);

    // Randomized mix of accesses.
    for (int n = 0; n < 300; n++) begin
      vid_blank = 1'($urandom);
      case ($urandom_range(0, 7))
        0: reg_out(8'hED, 8'($urandom));
        1: reg_out(8'hEE, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(185, 255))
                                                        : 8'($urandom));
        2: begin
          splash_en = ($urandom_range(0, 3) == 0);
          reg_out(8'hEF, 8'($urandom));
          splash_en = 1'b0;
        end
        3, 4: pix_write(8'($urandom));
        5: pix_read();
        6: stat_read();
        default: begin
          p = 8'($urandom);
          if (p >= 8'hEC && p <= 8'hEF) p = 8'h12;
          a = ref_addr();
          start(1'($urandom), p, 8'($urandom));
          check("other_rdy", dout_rdy, 1'b0);
          check("other_strobes", {ram_ce, ram_we, ram_oce}, 3'b000);
          check("other_addr", ram_addr, a);
          check("other_dout", dout, ref_dout);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
